// File: rtl/regbank_pkg.sv
// ============================================================================
// regbank_pkg : shared geometry of the 16x32 register bank.
// Rev 1.0
// ============================================================================
`default_nettype none

package regbank_pkg;
  localparam int REG_AW   = 4;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 16;
  localparam logic [REG_AW-1:0] REG_ZERO = 4'd0;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, scanning from ptr upward mod NREQ.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any_gnt
);
  import regbank_pkg::*;

  int w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!any_gnt && req[w_idx]) begin
        any_gnt      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = PW'(w_idx);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/regbank_write_arbiter.sv
// ============================================================================
// regbank_write_arbiter : round-robin sharing of the register bank write port,
// with a registered write stage and a saturating contention counter.
// Optional macro REGBANK_R0_ZERO_EN suppresses bank writes to r0.
// Rev 1.0
// ============================================================================
`default_nettype none

module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_dest,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  ack,
  output logic             wr_en,
  output logic [AW-1:0]    wr_dest,
  output logic [DW-1:0]    wr_data,
  output logic [15:0]      conflicts
);
  localparam int C_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [C_PW-1:0] w_idx;
  logic            w_any;
  logic [C_PW-1:0] w_ptr_nxt;
  logic [AW-1:0]   w_dest;
  logic [DW-1:0]   w_data;
  logic            w_wr_ok;
  logic            w_multi;

  logic [C_PW-1:0] r_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_dest;
  logic [DW-1:0]   r_wr_data;
  logic [15:0]     r_conflicts;

  assign w_req = stall ? '0 : req;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (C_PW)
  ) u_rr_arbiter (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .any_gnt (w_any)
  );

  assign w_ptr_nxt = (w_idx == C_PW'(NREQ - 1)) ? '0 : w_idx + C_PW'(1);
  assign w_dest    = req_dest[w_idx*AW +: AW];
  assign w_data    = req_data[w_idx*DW +: DW];
  assign w_multi   = ($countones(req) >= 2);

`ifdef REGBANK_R0_ZERO_EN
  // r0 grants still consume the slot and advance ptr; only the strobe is dropped
  assign w_wr_ok = w_any && (w_dest != AW'(REG_ZERO));
`else
  assign w_wr_ok = w_any;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_dest   <= '0;
      r_wr_data   <= '0;
      r_conflicts <= '0;
    end else begin
      r_wr_en <= w_wr_ok;
      if (w_wr_ok) begin
        r_wr_dest <= w_dest;
        r_wr_data <= w_data;
      end
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
      end
      if (!stall && w_multi && (r_conflicts != 16'hFFFF)) begin
        r_conflicts <= r_conflicts + 16'd1;
      end
    end
  end

  assign ack       = w_gnt & {NREQ{rst_n}};
  assign wr_en     = r_wr_en;
  assign wr_dest   = r_wr_dest;
  assign wr_data   = r_wr_data;
  assign conflicts = r_conflicts;
endmodule

`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
// ============================================================================
// tb_regbank_write_arbiter : directed and random stimulus against a reference
// model of the round-robin write arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regbank_write_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*AW-1:0] req_dest = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic              wr_en;
  logic [AW-1:0]     wr_dest;
  logic [DW-1:0]     wr_data;
  logic [15:0]       conflicts;

  regbank_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req       (req),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .ack       (ack),
    .wr_en     (wr_en),
    .wr_dest   (wr_dest),
    .wr_data   (wr_data),
    .conflicts (conflicts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int          m_ptr;
  logic        m_wr_en;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;
  int          m_conf;
  int          last_win;

  // random-phase requester bookkeeping
  bit          pend [NREQ];
  int          waitc [NREQ];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_wr_en = 1'b0; m_dest = '0; m_data = '0; m_conf = 0;
  endtask

  // winner = set requester at the smallest circular distance from ptr
  function automatic int pick();
    int best = -1;
    int bestd = NREQ;
    if (stall) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int d = (i - m_ptr + NREQ) % NREQ;
      if (req[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  // inputs are driven before the call (at a falling edge); returns at the next falling edge
  task automatic step(input bit chk);
    int w;
    int nreq_set;
    logic [AW-1:0] d;
    #1;
    w = pick();
    last_win = w;
    if (chk) check_val("ack", 64'(ack), (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge clk);
    nreq_set = 0;
    for (int i = 0; i < NREQ; i++) nreq_set += int'(req[i]);
    if (!stall && nreq_set >= 2 && m_conf < 65535) m_conf++;
    if (w >= 0) begin
      d = req_dest[w*AW +: AW];
      m_ptr = (w + 1) % NREQ;
`ifdef REGBANK_R0_ZERO_EN
      m_wr_en = (d != '0);
`else
      m_wr_en = 1'b1;
`endif
      if (m_wr_en) begin
        m_dest = d;
        m_data = req_data[w*DW +: DW];
      end
    end else begin
      m_wr_en = 1'b0;
    end
    @(negedge clk);
    if (chk) begin
      check_val("wr_en", 64'(wr_en), 64'(m_wr_en));
      check_val("wr_dest", 64'(wr_dest), 64'(m_dest));
      check_val("wr_data", 64'(wr_data), 64'(m_data));
      check_val("conflicts", 64'(conflicts), 64'(m_conf));
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input bit s);
    req = r; stall = s;
  endtask

  initial begin
    model_reset();
    // power-on reset with all requesters pending
    req = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_dest[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = 32'h1000_0000 + i;
    end
    @(negedge clk); @(negedge clk);
    check_val("rst_ack", 64'(ack), 64'd0);
    check_val("rst_wr_en", 64'(wr_en), 64'd0);
    check_val("rst_conflicts", 64'(conflicts), 64'd0);
    rst_n = 1'b1;
    step(1);
    check_val("first_ack_req0", 64'(last_win), 64'd0);

    // single request
    req_dest[1*AW +: AW] = 4'd5;
    req_data[1*DW +: DW] = 32'hDEADBEEF;
    drive(3'b010, 1'b0);
    step(1);
    check_val("single_dest", 64'(wr_dest), 64'd5);
    check_val("single_data", 64'(wr_data), 64'hDEADBEEF);

    // wrap/skip: ptr now 2, requester 2 idle
    drive(3'b011, 1'b0);
    step(1);
    check_val("wrap_ack0", 64'(last_win), 64'd0);
    step(1);
    check_val("wrap_ack1", 64'(last_win), 64'd1);

    // full contention round-robin, six cycles
    drive(3'b111, 1'b0);
    for (int c = 0; c < 6; c++) step(1);

    // stall
    drive(3'b001, 1'b1);
    for (int c = 0; c < 3; c++) step(1);
    drive(3'b001, 1'b0);
    step(1);
    check_val("post_stall_ack", 64'(last_win), 64'd0);

    // stalled contention must not count
    drive(3'b111, 1'b1);
    step(1);

    // write to r0
    req_dest[0*AW +: AW] = 4'd0;
    req_data[0*DW +: DW] = 32'd7;
    drive(3'b001, 1'b0);
    step(1);

    // asynchronous reset mid-write
    drive(3'b111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_ack", 64'(ack), 64'd0);
    check_val("midrst_wr_en", 64'(wr_en), 64'd0);
    check_val("midrst_conflicts", 64'(conflicts), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_val("midrst_first_ack", 64'(last_win), 64'd0);

    // randomized requesters that hold until acked
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          waitc[i] = 0;
          req_dest[i*AW +: AW] = AW'($urandom_range(0, 15));
          req_data[i*DW +: DW] = $urandom;
        end
        req[i] = pend[i];
      end
      stall = ($urandom_range(0, 7) == 0);
      step(1);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if (i == last_win) pend[i] = 1'b0;
          else if (!stall) begin
            waitc[i]++;
            if (waitc[i] >= NREQ) begin
              check_val("fairness", 64'(waitc[i]), 64'(NREQ - 1));
              waitc[i] = 0;
            end
          end
        end
      end
    end

    // long contention to saturate conflicts
    drive(3'b111, 1'b0);
    for (int c = 0; c < 65540; c++) step(0);
    step(1);
    check_val("conflicts_sat", 64'(conflicts), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
